if_instr_queue: RTL and testbench
=================================

# if_instr_queue

Instruction fetch queue between the AXI fetch interface and the decode stage. It buffers returned instruction/PC pairs in a small FIFO and presents them to decode with a valid/ready handshake. It issues fetch credits so the number of outstanding bus reads plus queued entries never exceeds the queue depth. On a pipeline redirect it discards stale, in-flight responses.

## Interface
Parameters:
- DEPTH, 4, number of entries; must be a power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  redirect from branch/exception; kills queue contents and in-flight fetches
- req_fire  in  1  fetch request accepted on bus (arvalid & arready of fetch interface)
- req_allow  out  1  fetch may issue a new request; gates instr_rd_en
- resp_valid  in  1  fetch response complete (rlast of fetch interface)
- resp_instr  in  `BUS_DATA_INSTR (32)  returned instruction
- resp_pc  in  `BUS_ADDR_MEM (64)  PC of returned instruction
- out_valid  out  1  instruction available to decode
- out_instr  out  32  head instruction
- out_pc  out  64  head PC
- out_ready  in  1  decode accepts head
- count  out  PTR_W+1  queued entries
- outstanding  out  PTR_W+1  issued-but-unreturned fetches
- drop_pending  out  1  stale responses still to be discarded
- overflow_err  out  1  sticky; a response arrived while the queue was full and not dropping

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instr}. wr_ptr and rd_ptr are PTR_W+1 bits and wrap modulo 2·DEPTH. count = wr_ptr − rd_ptr. Empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
- outstanding: +1 on req_fire, −1 on resp_valid, unchanged when both occur. Every response decrements it, including dropped ones.
- req_allow = !flush && (count + outstanding < DEPTH), with the sum taken in PTR_W+2 bits.
- drop_cnt (internal, PTR_W+1 bits); drop_pending = (drop_cnt != 0).
- A response is accepted when resp_valid && !flush && drop_cnt==0.
  - Accepted and not full: the entry is written at wr_ptr.
  - Accepted while full: the data is discarded and overflow_err is set. overflow_err clears only on reset.
- While drop_cnt != 0, each resp_valid decrements drop_cnt and is not written.
- Pop: out_valid && out_ready advances rd_ptr. A simultaneous push and pop leaves count unchanged.
- out_valid = !empty && !flush. out_instr/out_pc always show the head entry.
- Flush cycle:
  - Both pointers reset to 0.
  - Any response in the same cycle is discarded.
  - drop_cnt <= outstanding + req_fire − resp_valid, so any request fired in the flush cycle is also dropped.
  - outstanding updates normally.
- Reset values: all pointers, counters and drop_cnt 0; out_valid 0; out_instr/out_pc 0; overflow_err 0; req_allow 1; drop_pending 0.

## Timing
- Response-to-out_valid latency: 1 cycle (registered write, read next cycle); 0 cycles in bypass (see Configuration).
- req_allow is combinational from registered state and flush. req_fire is counted in the cycle it occurs.
- Flush takes effect immediately: out_valid drops in the flush cycle, and the queue is empty from the next cycle.
- Reset mid-operation clears all state asynchronously. Responses after reset are accepted as new data; the bus interface must itself be reset.

## Configuration
- IQ_BYPASS_EN defined: if the queue is empty, a response is accepted, out_ready=1 and there is no flush, then out_valid=1 with out_instr/out_pc = resp_instr/resp_pc in the same cycle. The entry is not written and count is unchanged. If out_ready=0, the entry is written as normal.
- IQ_BYPASS_EN undefined: every instruction passes through storage, giving a minimum 1-cycle latency.

## Test plan
- Reset, then idle → out_valid=0, req_allow=1, count=0, outstanding=0, overflow_err=0.
- 4 req_fire, then 4 responses with PC 0x80000000, 0x80000004, 0x80000008, 0x8000000C, out_ready=0 → req_allow=0 after the 4th fire; count=4; with out_ready=1, drains in PC order over 4 cycles and req_allow returns to 1.
- outstanding=2, flush pulse → drop_pending=1; the next 2 responses (instr 0xDEADBEEF) are not queued; drop_pending=0; the 3rd response (PC 0x80000100) appears at out_pc.
- count=2, push and pop in the same cycle → count stays 2 and ordering is preserved.
- Queue full, resp_valid with no drop pending → overflow_err=1 (sticky); head entry unchanged.
- IQ_BYPASS_EN, queue empty, out_ready=1, response 0x00000013 at PC 0x80000000 → out_valid=1 in the same cycle and count remains 0.

Source files
------------

// File: rtl/if_instr_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// The queue connects through the slave modport; the fetch/decode side uses the master modport.
interface if_instr_queue_if #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic             flush;
    logic             req_fire;
    logic             req_allow;
    logic             resp_valid;
    logic [31:0]      resp_instr;
    logic [63:0]      resp_pc;
    logic             out_valid;
    logic [31:0]      out_instr;
    logic [63:0]      out_pc;
    logic             out_ready;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   outstanding;
    logic             drop_pending;
    logic             overflow_err;

    modport master (
        output flush, req_fire, resp_valid, resp_instr, resp_pc, out_ready,
        input  req_allow, out_valid, out_instr, out_pc, count, outstanding,
               drop_pending, overflow_err
    );

    modport slave (
        input  flush, req_fire, resp_valid, resp_instr, resp_pc, out_ready,
        output req_allow, out_valid, out_instr, out_pc, count, outstanding,
               drop_pending, overflow_err
    );
endinterface

// File: rtl/if_instr_queue.sv
// Instruction fetch queue: credit-limited FIFO of {pc, instr} between fetch and decode.
// Optional same-cycle bypass of an empty queue is enabled by defining IQ_BYPASS_EN.
module if_instr_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             rst_n,
    if_instr_queue_if.slave bus
);
    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

    logic [95:0]    mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] outstanding_q, outstanding_d;
    logic [PTR_W:0] drop_cnt_q, drop_cnt_d;
    logic           overflow_q, overflow_d;

    logic           empty_s;
    logic           full_s;
    logic           accept_s;
    logic           bypass_s;
    logic           push_s;
    logic           pop_s;
    logic [PTR_W:0] count_s;
    logic [PTR_W+1:0] credit_sum_s;

    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count_s  = wr_ptr_q - rd_ptr_q;
    assign accept_s = bus.resp_valid && !bus.flush && (drop_cnt_q == '0);

`ifdef IQ_BYPASS_EN
    assign bypass_s = accept_s && empty_s && bus.out_ready;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = accept_s && !full_s && !bypass_s;
    assign pop_s  = !empty_s && !bus.flush && bus.out_ready;
    assign credit_sum_s = {1'b0, count_s} + {1'b0, outstanding_q};

    // Next-state computation for pointers, credits, drop counter and sticky error.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        overflow_d    = overflow_q;

        case ({bus.req_fire, bus.resp_valid})
            2'b10:   outstanding_d = outstanding_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   outstanding_d = outstanding_q - {{PTR_W{1'b0}}, 1'b1};
            default: outstanding_d = outstanding_q;
        endcase

        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Requests fired during the flush are still in flight, so they are dropped too.
            drop_cnt_d = outstanding_q + {{PTR_W{1'b0}}, bus.req_fire}
                                       - {{PTR_W{1'b0}}, bus.resp_valid};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (bus.resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - {{PTR_W{1'b0}}, 1'b1};
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (accept_s && full_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 96'h0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.resp_pc, bus.resp_instr};
        end
    end

    // Output drive: head entry, or the incoming response when bypassing an empty queue.
    always_comb begin
        bus.out_valid    = (!empty_s || bypass_s) && !bus.flush;
        if (bypass_s) begin
            bus.out_pc    = bus.resp_pc;
            bus.out_instr = bus.resp_instr;
        end else begin
            bus.out_pc    = mem_q[rd_ptr_q[PTR_W-1:0]][95:32];
            bus.out_instr = mem_q[rd_ptr_q[PTR_W-1:0]][31:0];
        end
        bus.req_allow    = !bus.flush && (credit_sum_s < DEPTH_W);
        bus.count        = count_s;
        bus.outstanding  = outstanding_q;
        bus.drop_pending = (drop_cnt_q != '0);
        bus.overflow_err = overflow_q;
    end
endmodule

// File: tb/tb_if_instr_queue.sv
// Directed self-checking bench for if_instr_queue (default DEPTH=4); follows IQ_BYPASS_EN.
module tb_if_instr_queue;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    if_instr_queue_if #(.DEPTH(4)) ifc ();

    if_instr_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.req_fire = 1'b1;
            step();
        end
        ifc.req_fire = 1'b0;
    endtask

    task automatic respond(input logic [63:0] pc, input logic [31:0] instr);
        ifc.resp_valid = 1'b1;
        ifc.resp_pc    = pc;
        ifc.resp_instr = instr;
        step();
        ifc.resp_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        ifc.flush      = 1'b0;
        ifc.req_fire   = 1'b0;
        ifc.resp_valid = 1'b0;
        ifc.resp_instr = 32'h0;
        ifc.resp_pc    = 64'h0;
        ifc.out_ready  = 1'b0;
        #12;
        check_eq("rst_out_valid", {63'h0, ifc.out_valid}, 64'h0);
        check_eq("rst_req_allow", {63'h0, ifc.req_allow}, 64'h1);
        check_eq("rst_out_pc", ifc.out_pc, 64'h0);
        rst_n = 1'b1;
        step();
        check_eq("idle_count", {61'h0, ifc.count}, 64'h0);
        check_eq("idle_outstanding", {61'h0, ifc.outstanding}, 64'h0);
        check_eq("idle_overflow", {63'h0, ifc.overflow_err}, 64'h0);
        check_eq("idle_drop_pending", {63'h0, ifc.drop_pending}, 64'h0);

        // Fill with four fetches, then drain in order.
        fire(3);
        check_eq("fire3_req_allow", {63'h0, ifc.req_allow}, 64'h1);
        fire(1);
        check_eq("fire4_outstanding", {61'h0, ifc.outstanding}, 64'h4);
        check_eq("fire4_req_allow", {63'h0, ifc.req_allow}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            respond(64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
        end
        check_eq("fill_count", {61'h0, ifc.count}, 64'h4);
        check_eq("fill_outstanding", {61'h0, ifc.outstanding}, 64'h0);
        check_eq("fill_req_allow", {63'h0, ifc.req_allow}, 64'h0);
        check_eq("fill_out_valid", {63'h0, ifc.out_valid}, 64'h1);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("drain_pc", ifc.out_pc, 64'h8000_0000 + 64'(4 * i));
            check_eq("drain_instr", {32'h0, ifc.out_instr}, 64'h100 + 64'(i));
            step();
        end
        ifc.out_ready = 1'b0;
        check_eq("drain_count", {61'h0, ifc.count}, 64'h0);
        check_eq("drain_req_allow", {63'h0, ifc.req_allow}, 64'h1);
        check_eq("drain_out_valid", {63'h0, ifc.out_valid}, 64'h0);

        // Flush with one queued entry and two fetches in flight.
        fire(3);
        respond(64'h8000_0050, 32'h55);
        check_eq("preflush_count", {61'h0, ifc.count}, 64'h1);
        check_eq("preflush_outstanding", {61'h0, ifc.outstanding}, 64'h2);
        ifc.flush = 1'b1;
        #1;
        check_eq("flush_out_valid", {63'h0, ifc.out_valid}, 64'h0);
        check_eq("flush_req_allow", {63'h0, ifc.req_allow}, 64'h0);
        step();
        ifc.flush = 1'b0;
        check_eq("postflush_count", {61'h0, ifc.count}, 64'h0);
        check_eq("postflush_drop", {63'h0, ifc.drop_pending}, 64'h1);
        respond(64'h8000_0F00, 32'hDEAD_BEEF);
        check_eq("drop1_pending", {63'h0, ifc.drop_pending}, 64'h1);
        check_eq("drop1_outstanding", {61'h0, ifc.outstanding}, 64'h1);
        respond(64'h8000_0F04, 32'hDEAD_BEEF);
        check_eq("drop2_pending", {63'h0, ifc.drop_pending}, 64'h0);
        check_eq("drop2_count", {61'h0, ifc.count}, 64'h0);
        check_eq("drop2_out_valid", {63'h0, ifc.out_valid}, 64'h0);
        fire(1);
        respond(64'h8000_0100, 32'h11);
        check_eq("after_drop_pc", ifc.out_pc, 64'h8000_0100);
        check_eq("after_drop_instr", {32'h0, ifc.out_instr}, 64'h11);
        check_eq("after_drop_count", {61'h0, ifc.count}, 64'h1);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        check_eq("after_drop_pop", {61'h0, ifc.count}, 64'h0);

        // Simultaneous push and pop at count 2.
        fire(3);
        respond(64'h8000_00A0, 32'hA0);
        respond(64'h8000_00A4, 32'hA4);
        check_eq("pp_count_before", {61'h0, ifc.count}, 64'h2);
        ifc.out_ready  = 1'b1;
        ifc.resp_valid = 1'b1;
        ifc.resp_pc    = 64'h8000_00A8;
        ifc.resp_instr = 32'hA8;
        #1;
        check_eq("pp_head", ifc.out_pc, 64'h8000_00A0);
        step();
        ifc.resp_valid = 1'b0;
        check_eq("pp_count_after", {61'h0, ifc.count}, 64'h2);
        check_eq("pp_order1", ifc.out_pc, 64'h8000_00A4);
        step();
        check_eq("pp_order2", ifc.out_pc, 64'h8000_00A8);
        step();
        ifc.out_ready = 1'b0;
        check_eq("pp_empty", {61'h0, ifc.count}, 64'h0);

        // Overflow: fifth response into a full queue.
        fire(5);
        check_eq("ovf_outstanding", {61'h0, ifc.outstanding}, 64'h5);
        for (int i = 0; i < 4; i++) begin
            respond(64'h8000_00C0 + 64'(4 * i), 32'hC0 + 32'(i));
        end
        check_eq("ovf_pre_err", {63'h0, ifc.overflow_err}, 64'h0);
        respond(64'h8000_00D0, 32'hD0);
        check_eq("ovf_err", {63'h0, ifc.overflow_err}, 64'h1);
        check_eq("ovf_count", {61'h0, ifc.count}, 64'h4);
        check_eq("ovf_head", ifc.out_pc, 64'h8000_00C0);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        ifc.out_ready = 1'b0;
        check_eq("ovf_drained", {61'h0, ifc.count}, 64'h0);
        check_eq("ovf_sticky", {63'h0, ifc.overflow_err}, 64'h1);

        // Empty queue with out_ready=1: bypass or one-cycle latency.
        fire(1);
        ifc.out_ready  = 1'b1;
        ifc.resp_valid = 1'b1;
        ifc.resp_pc    = 64'h8000_0000;
        ifc.resp_instr = 32'h0000_0013;
        #1;
`ifdef IQ_BYPASS_EN
        check_eq("byp_valid", {63'h0, ifc.out_valid}, 64'h1);
        check_eq("byp_instr", {32'h0, ifc.out_instr}, 64'h13);
        check_eq("byp_pc", ifc.out_pc, 64'h8000_0000);
        step();
        ifc.resp_valid = 1'b0;
        check_eq("byp_count", {61'h0, ifc.count}, 64'h0);
        check_eq("byp_after_valid", {63'h0, ifc.out_valid}, 64'h0);
`else
        check_eq("lat_same_cycle", {63'h0, ifc.out_valid}, 64'h0);
        step();
        ifc.resp_valid = 1'b0;
        check_eq("lat_valid", {63'h0, ifc.out_valid}, 64'h1);
        check_eq("lat_instr", {32'h0, ifc.out_instr}, 64'h13);
        check_eq("lat_count", {61'h0, ifc.count}, 64'h1);
        step();
        check_eq("lat_popped", {61'h0, ifc.count}, 64'h0);
`endif
        ifc.out_ready = 1'b0;

        // Asynchronous reset mid-cycle clears everything including the sticky error.
        fire(1);
        respond(64'h8000_0200, 32'h22);
        check_eq("prerst_count", {61'h0, ifc.count}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_overflow", {63'h0, ifc.overflow_err}, 64'h0);
        check_eq("arst_count", {61'h0, ifc.count}, 64'h0);
        check_eq("arst_out_valid", {63'h0, ifc.out_valid}, 64'h0);
        check_eq("arst_out_pc", ifc.out_pc, 64'h0);
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
